priority_arbiter_4: RTL



---
 rtl/priority_arbiter_4.sv | 119 +++++++++++
 1 files changed

// File: rtl/priority_arbiter_4.sv
// Four-requester arbiter: registered one-hot grant with encoded index, hold timeout,
// and one forced idle cycle between owners. Define ROUND_ROBIN_EN for rotating priority.
module priority_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout,
  output logic       state_dbg
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state, state_n;
  logic [3:0]    gnt_n;
  logic [1:0]    gnt_id_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          timeout_n;
  logic [1:0]    win_id;

`ifdef ROUND_ROBIN_EN
  logic [1:0] last_id, last_n;
  logic [1:0] cand;

  // Walk the order from last place to first so the highest-ranked requester overwrites.
  always_comb begin
    win_id = 2'd0;
    cand   = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_id - 2'(k);
      if (req[cand]) win_id = cand;
    end
  end
`else
  always_comb begin
    win_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) win_id = 2'(i);
    end
  end
`endif

  // Handshake: a client owns the resource while its gnt bit is high; it ends
  // ownership by asserting done or dropping req, else it is revoked at MAX_HOLD.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    hold_n    = hold_cnt;
    timeout_n = 1'b0;
`ifdef ROUND_ROBIN_EN
    last_n    = last_id;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_n  = GRANT;
          gnt_n    = 4'b0001 << win_id;
          gnt_id_n = win_id;
          hold_n   = HW'(1);
`ifdef ROUND_ROBIN_EN
          last_n   = win_id;
`endif
        end
      end
      GRANT: begin
        if (done || !req[gnt_id] || (hold_cnt == HW'(MAX_HOLD))) begin
          state_n   = IDLE;
          gnt_n     = 4'b0000;
          gnt_id_n  = 2'd0;
          hold_n    = '0;
          // Voluntary release takes precedence over the timeout.
          timeout_n = !done && req[gnt_id];
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        gnt_n    = 4'b0000;
        gnt_id_n = 2'd0;
        hold_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      gnt_id   <= 2'd0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_id  <= 2'd0;
`endif
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      hold_cnt <= hold_n;
      timeout  <= timeout_n;
`ifdef ROUND_ROBIN_EN
      last_id  <= last_n;
`endif
    end
  end

  assign gnt_valid = |gnt;
  assign state_dbg = state;

endmodule
